imem_byte_loader: RTL
=====================

// Module: imem_byte_loader
// PURPOSE
//   Write-side counterpart of the byte-addressed instruction memory. Receives an
//   assembled program as a framed byte stream and writes it one byte per cycle
//   into the memory's byte write port, big-endian: the byte at address 4k is the
//   MSB of word k.
//   Holds the CPU in reset while loading. Releases it only after a verified checksum.
//   Sits between the host/UART byte source and the instruction memory.
// PARAMETERS
//   ADDR_W     9    byte-address width; memory depth = 2**ADDR_W bytes (512)
//   LEN_W      16   width of the frame length header
// PORTS
//   clk        in   1        rising-edge clock
//   rst        in   1        synchronous, active-high reset
//   start      in   1        one-cycle pulse that begins a load frame
//   in_valid   in   1        byte source has data
//   in_data    in   8        byte from source
//   in_ready   out  1        loader accepts in_data this cycle
//   mem_we     out  1        byte write strobe to instruction memory
//   mem_addr   out  ADDR_W   byte address of write
//   mem_wdata  out  8        byte to write
//   cpu_hold   out  1        holds the CPU reset while loading or after an error
//   done       out  1        level: last frame loaded and checksum matched
//   err        out  1        level: last frame rejected
//   byte_count out  ADDR_W+1 payload bytes written in the current frame
// BEHAVIOUR
//   Reset values: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=1,
//   done=0, err=0, byte_count=0. State = IDLE.
//   Handshake: a byte transfers on a cycle where in_valid && in_ready. Data is
//   sampled only on transfer cycles. in_ready is combinational from state.
//   in_ready is 1 in LEN_HI, LEN_LO, DATA and CSUM; it is 0 otherwise.
//   Frame format: LEN_HI, LEN_LO, then LEN payload bytes, then CSUM.
//   CSUM = sum of payload bytes mod 256.
//   FSM:
//     IDLE/DONE/ERR --start--> LEN_HI. This clears done, err, byte_count and the
//     checksum accumulator, and sets cpu_hold=1.
//     LEN_HI --xfer--> LEN_LO.
//     LEN_LO --xfer--> one of:
//       ERR  if LEN > 2**ADDR_W or LEN[1:0]!=0 (whole words only);
//       CSUM if LEN==0;
//       DATA otherwise.
//     DATA: each transfer registers mem_we=1, mem_addr=byte_count[ADDR_W-1:0]
//     and mem_wdata=in_data. These are visible the next cycle. This is a fixed
//     latency of 1. mem_we stays high for exactly one cycle per byte.
//     byte_count increments on each transfer. The accumulator adds in_data.
//     After transfer number LEN, the FSM goes to CSUM.
//     CSUM --xfer--> DONE if in_data == accumulator, otherwise ERR.
//     DONE: done=1, cpu_hold=0.
//     ERR: err=1, cpu_hold stays 1.
//   start while in LEN_HI..CSUM is ignored. No restart mid-frame.
//   Back-to-back bytes with in_valid held high stream at one byte per cycle, with
//   no bubbles.
//   Length == 2**ADDR_W fills the memory exactly. The last address is 2**ADDR_W-1
//   and the address never wraps.
//   rst mid-frame aborts to IDLE with reset values. Memory contents already
//   written are not cleared; cpu_hold returns to 1.
//   Arithmetic: the accumulator is 8-bit with wrap-around. byte_count is
//   ADDR_W+1 bits so that a full-memory load counts to 2**ADDR_W.
// STRUCTURE
//   Shared package imem_pkg:
//     - state enum (IDLE, LEN_HI, LEN_LO, DATA, CSUM, DONE, ERR);
//     - IMEM_ADDR_W=9;
//     - IMEM_BYTES=512;
//     - LOAD_LEN_W=16.
//   The instruction memory gains a byte write port (we, addr, wdata) driven
//   only by this block.
//   One sub-module: imem_csum_acc, an 8-bit clear/add accumulator with a
//   compare output.
// TESTING
//   1. Basic load: start, then 00 0C, the 12 bytes 00 43 08 20 00 43 08 22 00 62
//      08 20, then CSUM.
//      -> 12 mem_we pulses at addresses 0..11; done=1; cpu_hold=0.
//      -> Read back word@0=0x00430820, word@4=0x00430822, word@8=0x00620820.
//   2. Bad checksum: same frame with CSUM XOR 0x01.
//      -> All 12 bytes are written; err=1; done=0; cpu_hold=1.
//   3. Length errors:
//      - LEN=0x0006 -> ERR right after LEN_LO, with no mem_we.
//      - LEN=0x0204 -> ERR.
//      - LEN=0x0000 followed by CSUM=00 -> DONE.
//   4. Full memory: LEN=0x0200 with in_valid held high.
//      -> 512 consecutive mem_we cycles; last mem_addr=0x1FF; byte_count=512;
//         done=1.
//   5. Throttling and abort:
//      - in_valid toggled randomly -> writes occur only on transfer cycles and
//        data is unchanged.
//      - rst after byte 5 -> IDLE, cpu_hold=1, no further mem_we.
//      - A fresh start then loads normally.
//   6. start pulsed during DATA -> ignored; the frame completes normally.

Source files
------------

// File: rtl/imem_pkg.sv
// imem_pkg
//   Shared definitions for the instruction-memory byte loader.
//   - load_state_e : loader FSM states (explicit encodings so the loader can
//                    keep its state register as a plain logic vector)
//   - IMEM_ADDR_W  : byte-address width of the instruction memory
//   - IMEM_BYTES   : instruction memory depth in bytes
//   - LOAD_LEN_W   : width of the frame length header
//   - len_legal()  : frame length acceptance rule
package imem_pkg;

  localparam int unsigned IMEM_ADDR_W = 9;
  localparam int unsigned IMEM_BYTES  = 512;
  localparam int unsigned LOAD_LEN_W  = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_HI = 3'd1,
    LEN_LO = 3'd2,
    DATA   = 3'd3,
    CSUM   = 3'd4,
    DONE   = 3'd5,
    ERR    = 3'd6
  } load_state_e;

  // A frame is accepted only if it fits in the memory and carries whole
  // 32-bit words. A 33-bit cap keeps the comparison exact for any addr_w < 32.
  function automatic logic len_legal(input logic [31:0] len,
                                     input int unsigned addr_w);
    logic [32:0] cap;
    cap = 33'd1 << addr_w;
    return ({1'b0, len} <= cap) && (len[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/imem_csum_acc.sv
// imem_csum_acc
//   8-bit modulo-256 running sum of payload bytes with an equality compare
//   against a candidate checksum byte.
// Ports
//   clk       in   rising-edge clock
//   rst       in   synchronous, active-high reset (sum -> 0)
//   clr       in   clear the sum (start of frame)
//   add_en    in   add add_data into the sum this cycle
//   add_data  in   byte to accumulate
//   cmp_data  in   checksum byte to compare against the current sum
//   sum       out  current accumulator value
//   match     out  cmp_data equals sum (combinational)
module imem_csum_acc (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       add_en,
  input  logic [7:0] add_data,
  input  logic [7:0] cmp_data,
  output logic [7:0] sum,
  output logic       match
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sum <= 8'h00;
    end else if (add_en) begin
      sum <= sum + add_data;
    end
  end

  assign match = (cmp_data == sum);

endmodule

// File: rtl/imem_byte_loader.sv
// imem_byte_loader
//   Receives a framed byte stream (LEN_HI, LEN_LO, LEN payload bytes, CSUM)
//   and writes the payload one byte per cycle into the instruction memory's
//   byte write port, byte i at address i (big-endian words). The CPU is held
//   in reset until a frame completes with a matching checksum.
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous, active-high reset
//   start      in   one-cycle pulse that begins a frame (IDLE/DONE/ERR only)
//   in_valid   in   byte source has data
//   in_data    in   byte from source
//   in_ready   out  loader accepts in_data this cycle (combinational from state)
//   mem_we     out  byte write strobe, one cycle per payload byte
//   mem_addr   out  byte address of the write
//   mem_wdata  out  byte to write
//   cpu_hold   out  CPU reset hold; low only after a verified frame
//   done       out  last frame loaded with matching checksum
//   err        out  last frame rejected (bad length or checksum)
//   byte_count out  payload bytes written in the current frame
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | after reset, waiting for start
// LEN_HI | waiting for length header high byte
// LEN_LO | waiting for length header low byte; length is judged here
// DATA   | streaming payload bytes into memory
// CSUM   | waiting for checksum byte
// DONE   | frame verified, CPU released; start begins a new frame
// ERR    | frame rejected, CPU held; start begins a new frame
module imem_byte_loader
  import imem_pkg::*;
#(
  parameter int unsigned ADDR_W = IMEM_ADDR_W,
  parameter int unsigned LEN_W  = LOAD_LEN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   byte_count
);

  localparam logic [2:0] ST_IDLE   = IDLE;
  localparam logic [2:0] ST_LEN_HI = LEN_HI;
  localparam logic [2:0] ST_LEN_LO = LEN_LO;
  localparam logic [2:0] ST_DATA   = DATA;
  localparam logic [2:0] ST_CSUM   = CSUM;
  localparam logic [2:0] ST_DONE   = DONE;
  localparam logic [2:0] ST_ERR    = ERR;

  logic [2:0]       state_q;
  logic [2:0]       state_d;
  logic [7:0]       len_hi_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] len_rx;
  logic [ADDR_W:0]  count_nxt;
  logic             xfer;
  logic             start_ok;
  logic             data_xfer;
  logic             last_byte;
  logic             csum_match;
  logic [7:0]       csum_sum;

  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      ST_LEN_HI, ST_LEN_LO, ST_DATA, ST_CSUM: in_ready = 1'b1;
      default:                                in_ready = 1'b0;
    endcase
  end

  assign xfer      = in_valid && in_ready;
  assign start_ok  = start && ((state_q == ST_IDLE) || (state_q == ST_DONE) ||
                               (state_q == ST_ERR));
  assign data_xfer = xfer && (state_q == ST_DATA);

  // Full length as seen on the LEN_LO transfer cycle.
  assign len_rx    = LEN_W'({len_hi_q, in_data});
  assign count_nxt = byte_count + 1'b1;
  // byte_count never exceeds len_q, so comparing the incremented count
  // against the header identifies the final payload byte.
  assign last_byte = (LEN_W'(count_nxt) == len_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start_ok) state_d = ST_LEN_HI;
      end
      ST_LEN_HI: begin
        if (xfer) state_d = ST_LEN_LO;
      end
      ST_LEN_LO: begin
        if (xfer) begin
          if (!len_legal(32'(len_rx), ADDR_W)) begin
            state_d = ST_ERR;
          end else if (len_rx == '0) begin
            state_d = ST_CSUM;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (xfer && last_byte) state_d = ST_CSUM;
      end
      ST_CSUM: begin
        if (xfer) state_d = csum_match ? ST_DONE : ST_ERR;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      len_hi_q   <= 8'h00;
      len_q      <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= 8'h00;
      byte_count <= '0;
    end else begin
      state_q <= state_d;
      mem_we  <= 1'b0;
      if (start_ok) begin
        byte_count <= '0;
      end
      if (xfer && (state_q == ST_LEN_HI)) begin
        len_hi_q <= in_data;
      end
      if (xfer && (state_q == ST_LEN_LO)) begin
        len_q <= len_rx;
      end
      // Write port is registered: strobe, address and data appear one
      // cycle after the transfer. Address is the pre-increment count, so
      // the last legal byte lands at 2**ADDR_W-1 without wrapping.
      if (data_xfer) begin
        mem_we     <= 1'b1;
        mem_addr   <= byte_count[ADDR_W-1:0];
        mem_wdata  <= in_data;
        byte_count <= count_nxt;
      end
    end
  end

  imem_csum_acc u_csum (
    .clk      (clk),
    .rst      (rst),
    .clr      (start_ok),
    .add_en   (data_xfer),
    .add_data (in_data),
    .cmp_data (in_data),
    .sum      (csum_sum),
    .match    (csum_match)
  );

  assign done     = (state_q == ST_DONE);
  assign err      = (state_q == ST_ERR);
  assign cpu_hold = (state_q != ST_DONE);

endmodule
